// File: rtl/e_s_in_buf_pkg.sv
// Shared constants for the CPU input-side port block: default data width,
// CPU port-id encoding and the per-port FIFO depth.
package e_s_in_buf_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] PORT1 = 2'd0;
  localparam logic [1:0] PORT2 = 2'd1;
  localparam logic [1:0] PORT3 = 2'd2;
  localparam logic [1:0] PORT4 = 2'd3;

  localparam int         FIFO_DEPTH = 2;
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

endpackage

// File: rtl/e_s_in_buf_in_fifo2.sv
// Two-entry FIFO for one producer port. Single-bit pointers wrap naturally,
// a push into a full FIFO or a pop from an empty one is ignored, and the
// head reads as zero while the FIFO is empty.
module in_fifo2
  import e_s_in_buf_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/e_s_in_buf.sv
// Input-side I/O port block: four producer FIFOs, CPU head select, pending
// flags. Optional interrupt output enabled by defining E_S_IRQ_EN.
module e_s_in_buf
  import e_s_in_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             vld1,
  input  logic             vld2,
  input  logic             vld3,
  input  logic             vld4,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic             rdy4,
  input  logic [1:0]       id_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_in,
  output logic [3:0]       pend
`ifdef E_S_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] din  [4];
  logic [WIDTH-1:0] head [4];
  logic [3:0]       vld;
  logic [3:0]       full;
  logic [3:0]       empty;
  logic [3:0]       push;
  logic [3:0]       pop;

  assign din[0] = in1;
  assign din[1] = in2;
  assign din[2] = in3;
  assign din[3] = in4;
  assign vld    = {vld4, vld3, vld2, vld1};

  assign rdy1 = !full[0];
  assign rdy2 = !full[1];
  assign rdy3 = !full[2];
  assign rdy4 = !full[3];
  assign pend = ~empty;

  // Push on producer handshake; pop only the port the CPU currently selects.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = vld[k] && !full[k];
      pop[k]  = rd && (id_in == 2'(k));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_port
    in_fifo2 #(.W(WIDTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .din   (din[g]),
      .push  (push[g]),
      .pop   (pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Head byte of the selected port; each FIFO already presents zero when empty.
  always_comb begin
    data_in = '0;
    case (id_in)
      PORT1:   data_in = head[0];
      PORT2:   data_in = head[1];
      PORT3:   data_in = head[2];
      PORT4:   data_in = head[3];
      default: data_in = '0;
    endcase
  end

`ifdef E_S_IRQ_EN
  // Interrupt follows the registered pending flags one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |pend;
  end
`endif

endmodule

// File: tb/tb_e_s_in_buf.sv
// Directed bench for e_s_in_buf: per-port scoreboard queues filled on accepted
// pushes and drained on CPU reads. Define E_S_IRQ_EN to also cover irq.
module tb_e_s_in_buf;
  import e_s_in_buf_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic       vld1 = 1'b0, vld2 = 1'b0, vld3 = 1'b0, vld4 = 1'b0;
  logic       rdy1, rdy2, rdy3, rdy4;
  logic [1:0] id_in = 2'd0;
  logic       rd = 1'b0;
  logic [7:0] data_in;
  logic [3:0] pend;
`ifdef E_S_IRQ_EN
  logic       irq;
`endif

  int         checks = 0;
  int         passed = 0;
  logic [7:0] sb [4][$];

  e_s_in_buf #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .vld1    (vld1),
    .vld2    (vld2),
    .vld3    (vld3),
    .vld4    (vld4),
    .rdy1    (rdy1),
    .rdy2    (rdy2),
    .rdy3    (rdy3),
    .rdy4    (rdy4),
    .id_in   (id_in),
    .rd      (rd),
    .data_in (data_in),
    .pend    (pend)
`ifdef E_S_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int port, input logic [7:0] val, input logic v);
    case (port)
      0: begin in1 = val; vld1 = v; end
      1: begin in2 = val; vld2 = v; end
      2: begin in3 = val; vld3 = v; end
      default: begin in4 = val; vld4 = v; end
    endcase
  endtask

  // Single-cycle push; the byte is expected only if the port was ready.
  task automatic push_byte(input int port, input logic [7:0] val);
    drive_port(port, val, 1'b1);
    check_output("push_rdy", {28'd0, rdy4, rdy3, rdy2, rdy1} >> port & 32'd1, 32'd1);
    sb[port].push_back(val);
    step();
    drive_port(port, 8'h00, 1'b0);
  endtask

  // Select the port, compare its head with the oldest expected byte, consume it.
  task automatic read_port(input int port, input string tag);
    logic [7:0] exp;
    id_in = 2'(port);
    exp   = (sb[port].size() != 0) ? sb[port].pop_front() : 8'h00;
    #1;
    check_output(tag, {24'd0, data_in}, {24'd0, exp});
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  initial begin
    #1;
    check_output("reset_pend", {28'd0, pend}, 32'h0);
    check_output("reset_rdy", {28'd0, rdy4, rdy3, rdy2, rdy1}, 32'hf);
    check_output("reset_data", {24'd0, data_in}, 32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single transfer on port1
    push_byte(0, 8'hA5);
    id_in = PORT1;
    #1;
    check_output("single_pend", {28'd0, pend}, 32'h1);
    read_port(0, "single_data");
    check_output("single_pend_clr", {28'd0, pend}, 32'h0);
    check_output("single_data_clr", {24'd0, data_in}, 32'h0);

    // Backpressure on port3 with vld3 held high
    vld3 = 1'b1; in3 = 8'h11;
    sb[2].push_back(8'h11);
    step();
    in3 = 8'h22;
    sb[2].push_back(8'h22);
    step();
    in3 = 8'h33;
    check_output("bp_rdy_low", {31'd0, rdy3}, 32'h0);
    step();
    check_output("bp_rdy_held", {31'd0, rdy3}, 32'h0);
    read_port(2, "bp_first");
    check_output("bp_rdy_rise", {31'd0, rdy3}, 32'h1);
    check_output("bp_second_head", {24'd0, data_in}, 32'h22);
    sb[2].push_back(8'h33);
    step();
    vld3 = 1'b0;
    check_output("bp_refull", {31'd0, rdy3}, 32'h0);
    read_port(2, "bp_second");
    read_port(2, "bp_third");
    check_output("bp_drained", {28'd0, pend}, 32'h0);

    // Simultaneous push and pop on port4 holding one byte
    push_byte(3, 8'h40);
    id_in = PORT4;
    in4 = 8'h41; vld4 = 1'b1; rd = 1'b1;
    #1;
    check_output("sim_old_head", {24'd0, data_in}, {24'd0, sb[3].pop_front()});
    sb[3].push_back(8'h41);
    step();
    vld4 = 1'b0; rd = 1'b0;
    check_output("sim_pend", {31'd0, pend[3]}, 32'h1);
    check_output("sim_rdy4", {31'd0, rdy4}, 32'h1);
    read_port(3, "sim_new_head");
    check_output("sim_drained", {28'd0, pend}, 32'h0);

    // Empty read on port2 must not disturb port1
    push_byte(0, 8'h7E);
    id_in = PORT2; rd = 1'b1;
    step();
    rd = 1'b0;
    check_output("iso_data", {24'd0, data_in}, 32'h0);
    check_output("iso_pend", {28'd0, pend}, 32'h1);
    id_in = PORT1;
    #1;
    check_output("iso_port1", {24'd0, data_in}, {24'd0, sb[0][0]});

    // Asynchronous reset mid-cycle with port2 full
    push_byte(1, 8'hAA);
    push_byte(1, 8'hBB);
    id_in = PORT2;
    #1;
    check_output("pre_reset_full", {31'd0, rdy2}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_pend", {28'd0, pend}, 32'h0);
    check_output("async_rdy", {28'd0, rdy4, rdy3, rdy2, rdy1}, 32'hf);
    check_output("async_data", {24'd0, data_in}, 32'h0);
    for (int p = 0; p < 4; p++) sb[p].delete();
    step();
    reset = 1'b0;
    step();

`ifdef E_S_IRQ_EN
    check_output("irq_idle", {31'd0, irq}, 32'h0);
    push_byte(0, 8'h01);
    check_output("irq_lag_rise", {31'd0, irq}, 32'h0);
    step();
    check_output("irq_high", {31'd0, irq}, 32'h1);
    read_port(0, "irq_data");
    check_output("irq_lag_fall", {31'd0, irq}, 32'h1);
    step();
    check_output("irq_low", {31'd0, irq}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
